// File: rtl/ppi_bus_master_if.sv
// ppi_bus_master_if: host request/response and PPI control lines of the bus master.
interface ppi_bus_master_if;
    logic       req;
    logic       req_wr;
    logic [1:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       cs;
    logic [1:0] a;
    logic       read;
    logic       write;
    modport master (
        input  req, req_wr, req_addr, req_data,
        output busy, done, rd_data, cs, a, read, write
    );
    modport slave (
        output req, req_wr, req_addr, req_data,
        input  busy, done, rd_data, cs, a, read, write
    );
endinterface

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns one-cycle host requests into timed PPI read/write bus cycles.
module ppi_bus_master #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    ppi_bus_master_if.master     bus,
    inout  wire  [7:0]           data
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, wdata;
    logic       wr, wr_n, oe, accept, last;
    always_comb begin
        accept  = state == IDLE && bus.req;
        wr_n    = accept ? bus.req_wr : wr;
        last    = cnt == (state == SETUP ? 8'(SETUP_CYC - 1) :
                          state == PULSE ? 8'(PULSE_CYC - 1) : 8'(HOLD_CYC - 1));
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            state_n = SETUP;
            cnt_n   = '0;
        end else if (state != IDLE) begin
            cnt_n = last ? '0 : cnt + 8'd1;
            if (last)
                state_n = state == SETUP ? PULSE : state == PULSE ? HOLD : IDLE;
        end
    end
    // Outputs are computed from the next state so every bus line comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            wdata       <= '0;
            oe          <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_data <= '0;
            bus.cs      <= 1'b0;
            bus.a       <= '0;
            bus.read    <= 1'b0;
            bus.write   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr        <= wr_n;
            if (accept) begin
                wdata <= bus.req_data;
                bus.a <= bus.req_addr;
            end
            oe        <= state_n != IDLE && wr_n;
            bus.busy  <= state_n != IDLE;
            bus.cs    <= state_n != IDLE;
            bus.done  <= state == HOLD && state_n == IDLE;
            bus.read  <= state_n == PULSE && !wr_n;
            bus.write <= state_n == PULSE && wr_n;
            if (state == PULSE && last && !wr)
                bus.rd_data <= data;
        end
    end
    assign data = oe ? wdata : 8'bz;
endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: timeline model of the PPI bus master plus directed literal checks.
module tb_ppi_bus_master;
    localparam int S = 1, P = 2, H = 1, T = S + P + H;
    logic clk, reset;
    bit   chk_en;
    int   checks, errors;
    logic [7:0] drv_val;
    wire  [7:0] data, data2;
    ppi_bus_master_if bus ();
    ppi_bus_master_if bus2 ();
    ppi_bus_master dut (.clk(clk), .reset(reset), .bus(bus), .data(data));
    ppi_bus_master #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2), .data(data2));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Model: k is the cycle number counted from the accept edge of the current transfer.
    logic       active, m_wr;
    int         k;
    logic [1:0] m_a;
    logic [7:0] m_wd, m_rd;
    always @(posedge clk) begin
        if (reset) begin
            active <= 0;
            k      <= 0;
            m_a    <= 0;
            m_rd   <= 0;
            m_wr   <= 0;
        end else if ((!active || k == T + 1) && bus.req) begin
            active <= 1;
            k      <= 1;
            m_wr   <= bus.req_wr;
            m_a    <= bus.req_addr;
            m_wd   <= bus.req_data;
        end else if (active && k <= T) begin
            if (k == S + P && !m_wr) m_rd <= drv_val;
            k <= k + 1;
        end else
            active <= 0;
    end
    wire e_busy = active && k <= T;
    wire e_done = active && k == T + 1;
    wire e_stb  = e_busy && k > S && k <= S + P;
    wire e_rd   = e_stb && !m_wr;
    wire e_wr   = e_stb && m_wr;
    assign data = e_rd ? drv_val : 8'bz;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs", {bus.busy, bus.done, bus.cs, bus.a, bus.read, bus.write, bus.rd_data},
                {e_busy, e_done, e_busy, m_a, e_rd, e_wr, m_rd});
            if (e_busy && m_wr) chk("data_wr", data, m_wd);
            if (e_rd) chk("data_rd", data, drv_val);
        end
    end
    task automatic xfer(input logic wr, input logic [1:0] ad, input logic [7:0] d,
                        output logic [5:0] cv, output logic [5:0] sv, output logic [5:0] dv);
        bus.req = 1; bus.req_wr = wr; bus.req_addr = ad; bus.req_data = d;
        @(negedge clk);
        bus.req = 0;
        for (int n = 0; n < 6; n++) begin
            cv[n] = bus.cs;
            sv[n] = bus.read | bus.write;
            dv[n] = bus.done;
            @(negedge clk);
        end
    endtask
    logic [5:0]  cv, sv, dv;
    logic [11:0] c2, w2, d2;
    int          dn;
    initial begin
        reset = 1; chk_en = 0; drv_val = 8'h00;
        bus.req = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_data = 0;
        bus2.req = 0; bus2.req_wr = 0; bus2.req_addr = 0; bus2.req_data = 0;
        repeat (2) @(negedge clk);
        chk("reset_vals", {bus.busy, bus.done, bus.cs, bus.a, bus.read, bus.write, bus.rd_data}, 0);
        chk_en = 1;
        reset = 0;
        @(negedge clk);
        xfer(1, 3, 8'h80, cv, sv, dv);
        chk("wr_cs", cv, 6'b001111);
        chk("wr_strobe", sv, 6'b000110);
        chk("wr_done", dv, 6'b010000);
        drv_val = 8'h5A;
        xfer(0, 0, 8'hFF, cv, sv, dv);
        chk("rd_strobe", sv, 6'b000110);
        chk("rd_done", dv, 6'b010000);
        chk("rd_data_5a", bus.rd_data, 8'h5A);
        drv_val = 8'h3C;
        xfer(0, 1, 8'h00, cv, sv, dv);
        xfer(1, 2, 8'h11, cv, sv, dv);
        chk("rd_data_hold", bus.rd_data, 8'h3C);
        // REQ held high: one accept per DONE cycle, alternating direction.
        drv_val = 8'h96;
        dn = 0;
        bus.req = 1;
        for (int i = 0; i < 4; i++) begin
            bus.req_wr = (i % 2 == 0); bus.req_addr = 2'(i); bus.req_data = 8'(8'hA0 + i);
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                dn += int'(bus.done);
            end
        end
        bus.req = 0;
        chk("b2b_dones", dn, 4);
        chk("b2b_rd_data", bus.rd_data, 8'h96);
        repeat (2) @(negedge clk);
        bus.req = 1; bus.req_wr = 1; bus.req_addr = 1; bus.req_data = 8'hAA;
        @(negedge clk);
        bus.req = 0;
        @(negedge clk);
        bus.req = 1; bus.req_wr = 0; bus.req_addr = 2; bus.req_data = 8'h55;
        @(negedge clk);
        bus.req = 0;
        dn = 0;
        for (int j = 0; j < 8; j++) begin
            dn += int'(bus.done);
            @(negedge clk);
        end
        chk("ignored_req_dones", dn, 1);
        chk("ignored_req_addr", bus.a, 2'd1);
        drv_val = 8'h77;
        bus.req = 1; bus.req_wr = 0; bus.req_addr = 2;
        @(negedge clk);
        bus.req = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_reset", {bus.busy, bus.done, bus.cs, bus.a, bus.read, bus.write, bus.rd_data}, 0);
        reset = 0;
        dn = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            dn += int'(bus.done);
        end
        chk("mid_reset_no_done", dn, 0);
        bus2.req = 1; bus2.req_wr = 1; bus2.req_addr = 2; bus2.req_data = 8'h0F;
        @(negedge clk);
        bus2.req = 0;
        for (int n = 0; n < 12; n++) begin
            c2[n] = bus2.cs;
            w2[n] = bus2.write;
            d2[n] = bus2.done;
            if (bus2.cs) chk("p2_data", data2, 8'h0F);
            chk("p2_no_read", bus2.read, 1'b0);
            @(negedge clk);
        end
        chk("p2_cs", c2, 12'h1FF);
        chk("p2_write", w2, 12'h078);
        chk("p2_done", d2, 12'h200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
